rst_sequencer: RTL
==================

Name: rst_sequencer

Overview:
Parametrised reset/run controller for the pipeline CPU bench and SoC top. It replaces the single fixed reset pulse and fixed-time stop with a sequenced reset release, one active-low reset per channel (e.g. regfile, pipeline, memories, peripherals). It counts run cycles after release and raises a sticky done on CPU halt or on a cycle limit. It also supports soft re-reset without touching the global reset.

Parameters:
NUM_CH, 4, number of reset channels (>=1)
HOLD_CYCLES, 4, cycles all channels stay in reset after rst goes high (>=1)
STEP_CYCLES, 2, cycles between successive channel releases (>=1)
RUN_LIMIT, 1200, run cycles before done; 0 = no limit
CNT_W, 16, width of run_cycles counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk
sw_rst_req  in  1  soft reset request, single-cycle pulse
halt_in  in  1  CPU halt indication, level
ch_rst_n  out  NUM_CH  per-channel active-low reset, bit 0 released first
all_released  out  1  high when every ch_rst_n bit is 1
run_cycles  out  CNT_W  cycles spent in RUN, saturating
done  out  1  sticky completion flag
state  out  3  current FSM state, for debug

Behaviour:
- States: HOLD, RELEASE, RUN, DONE.
- Reset: any edge with rst==0 -> state=HOLD, cnt=0, idx=0, ch_rst_n=0, all_released=0, run_cycles=0, done=0. rst overrides every other input, including mid-RELEASE and DONE.
- Edge numbering: edge 1 is the first edge with rst==1.
- HOLD: cnt increments each edge. When cnt reaches HOLD_CYCLES-1, go to RELEASE and set ch_rst_n[0]=1 on that edge, so ch0 rises after edge HOLD_CYCLES.
- RELEASE: channel k rises after edge HOLD_CYCLES + k*STEP_CYCLES. Bits already released stay 1, and only one bit changes per release edge.
- Last channel: on the edge that releases channel NUM_CH-1, all_released<=1 and state<=RUN. With NUM_CH==1, HOLD goes directly to RUN.
- RUN: run_cycles increments each edge and saturates at all-ones, with no wrap.
- RUN exits: RUN_LIMIT!=0 and run_cycles==RUN_LIMIT-1 -> run_cycles<=RUN_LIMIT, done<=1, state<=DONE. halt_in==1 -> done<=1, state<=DONE, run_cycles still increments on that edge. Both conditions on the same edge -> DONE, single transition.
- DONE: outputs frozen and done held at 1 until rst or sw_rst_req.
- sw_rst_req in any state -> next edge: state=HOLD, cnt=0, idx=0, ch_rst_n=0, all_released=0, run_cycles=0, done=0. Sequencing then restarts exactly as after rst.
- sw_rst_req has priority over halt_in and over the limit in the same cycle.
- sw_rst_req in HOLD restarts the hold count.
- halt_in is ignored outside RUN.
- All outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- define.v additions:
  - `RstNEnable 1'b0 and `RstNDisable 1'b1
  - state encodings `SEQ_HOLD 3'd0, `SEQ_RELEASE 3'd1, `SEQ_RUN 3'd2, `SEQ_DONE 3'd3
- Sub-module seq_sat_counter: parametrised width, synchronous clear, enable, saturate at all-ones. Instantiated for cnt and for run_cycles.
- Top bench instantiates rst_sequencer, drives top_test reset from ch_rst_n, and calls $stop on done.

Test Plan:
- Nominal release: rst=0 for 3 edges then 1, defaults. Expect ch_rst_n 0000 through edge 3, then 0001@4, 0011@6, 0111@8, 1111@10. all_released=1 and state=RUN after edge 10.
- Cycle limit: RUN_LIMIT=5, halt_in=0. Expect done=1, state=DONE and run_cycles=5 after edge 15; values stay frozen for 20 further cycles.
- Halt: assert halt_in at run_cycles==3. Expect done=1 and run_cycles=4 on that edge, held thereafter. halt_in pulsed during HOLD has no effect.
- Soft reset mid-RELEASE: sw_rst_req on edge 7 with ch_rst_n=0011. Expect ch_rst_n=0000 and state=HOLD after edge 7. ch0 then rises after edge 11 and 1111 is reached after edge 17.
- Priority: sw_rst_req and halt_in together in RUN -> HOLD with done=0. rst=0 asserted in DONE -> all outputs return to reset values on the next edge.
- Corner parameters: NUM_CH=1, HOLD_CYCLES=1, RUN_LIMIT=0. Expect ch_rst_n=1 and RUN after edge 1; done never asserts. Force run_cycles near saturation with CNT_W=4: it holds at 15 with no wrap.

Source files
------------

// File: rtl/rst_sequencer_pkg.sv
// Shared types and helpers for the reset/run sequencer: FSM encoding,
// reset polarity names and parameter-derived width helpers.
package rst_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_HOLD    = 3'd0,
    SEQ_RELEASE = 3'd1,
    SEQ_RUN     = 3'd2,
    SEQ_DONE    = 3'd3
  } seq_state_e;

  localparam logic RST_N_ENABLE  = 1'b0;
  localparam logic RST_N_DISABLE = 1'b1;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int unsigned width_for(input int unsigned n);
    return (n <= 2) ? 1 : int'($clog2(n));
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sequencer_sat_counter.sv
// Up-counter with synchronous clear (priority over enable) that sticks at
// all-ones instead of wrapping.
module seq_sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rst_sequencer.sv
// Sequenced per-channel reset release followed by a run-cycle counter that
// ends in a sticky done on CPU halt or on a cycle limit.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned STEP_CYCLES = 2,
  parameter int unsigned RUN_LIMIT   = 1200,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req,
  input  logic              halt_in,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              all_released,
  output logic [CNT_W-1:0]  run_cycles,
  output logic              done,
  output logic [2:0]        state
);

  localparam int unsigned HC_W  = width_for(max_u(HOLD_CYCLES, STEP_CYCLES));
  localparam int unsigned IDX_W = width_for(NUM_CH);
  localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

  seq_state_e        state_q, state_d;
  logic [HC_W-1:0]   cnt;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic              all_rel_q, all_rel_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  run_cnt;
  logic              hold_exp, step_exp, last_step, limit_hit, run_exit;

  // idx_q is the most recently released channel; cnt times both the hold and each step.
  assign hold_exp  = (state_q == SEQ_HOLD) && (32'(cnt) == HOLD_CYCLES - 32'd1);
  assign step_exp  = (state_q == SEQ_RELEASE) && (32'(cnt) == STEP_CYCLES - 32'd1);
  assign last_step = (32'(idx_q) + 32'd1) == (NUM_CH - 32'd1);
  assign limit_hit = (RUN_LIMIT != 0) && (32'(run_cnt) == RUN_LIMIT - 32'd1);
  assign run_exit  = limit_hit || halt_in;

  seq_sat_counter #(.W(HC_W)) u_step_cnt (
    .clk_i   (clk),
    .rst_n_i (rst),
    .clr_i   (sw_rst_req || hold_exp || step_exp),
    .en_i    ((state_q == SEQ_HOLD) || (state_q == SEQ_RELEASE)),
    .cnt_o   (cnt)
  );

  seq_sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk_i   (clk),
    .rst_n_i (rst),
    .clr_i   (sw_rst_req),
    .en_i    (state_q == SEQ_RUN),
    .cnt_o   (run_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= SEQ_HOLD;
      idx_q     <= '0;
      ch_q      <= {NUM_CH{RST_N_ENABLE}};
      all_rel_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ch_q      <= ch_d;
      all_rel_q <= all_rel_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sw_rst_req) begin
      state_d = SEQ_HOLD;
    end else begin
      case (state_q)
        SEQ_HOLD:    if (hold_exp) state_d = (NUM_CH == 1) ? SEQ_RUN : SEQ_RELEASE;
        SEQ_RELEASE: if (step_exp && last_step) state_d = SEQ_RUN;
        SEQ_RUN:     if (run_exit) state_d = SEQ_DONE;
        SEQ_DONE:    state_d = SEQ_DONE;
        default:     state_d = SEQ_HOLD;
      endcase
    end
  end

  always_comb begin
    idx_d     = idx_q;
    ch_d      = ch_q;
    all_rel_d = all_rel_q;
    done_d    = done_q;
    if (sw_rst_req) begin
      idx_d     = '0;
      ch_d      = {NUM_CH{RST_N_ENABLE}};
      all_rel_d = 1'b0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        SEQ_HOLD: begin
          if (hold_exp) begin
            idx_d     = '0;
            ch_d[0]   = RST_N_DISABLE;
            all_rel_d = (NUM_CH == 1);
          end
        end
        SEQ_RELEASE: begin
          if (step_exp) begin
            idx_d     = idx_q + IDX_W'(1);
            ch_d      = ch_q | (CH_ONE << idx_d);
            all_rel_d = last_step;
          end
        end
        SEQ_RUN: if (run_exit) done_d = 1'b1;
        default: ;
      endcase
    end
  end

  assign ch_rst_n     = ch_q;
  assign all_released = all_rel_q;
  assign run_cycles   = run_cnt;
  assign done         = done_q;
  assign state        = state_q;

endmodule
